// File: rtl/peri_arb_pkg.sv
// Shared types and constants for the two-master peripheral bus arbiter.
package peri_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RELEASE
  } arb_state_e;

  localparam logic [1:0]  REQ_NONE   = 2'b11;
  localparam logic [31:0] ABORT_DATA = 32'hFFFF_FFFF;

  function automatic logic req_active(input logic [1:0] write_n, input logic [1:0] read_n);
    return (write_n != REQ_NONE) || (read_n != REQ_NONE);
  endfunction

endpackage

// File: rtl/peri_arb_req_latch.sv
// Captured request registers for the arbiter: selects one master's request and
// holds it on the bus for the whole transaction, or drives the bus idle.
module peri_arb_req_latch
  import peri_arb_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic              sel,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_data_in,
  input  logic [1:0]        m0_data_write_n,
  input  logic [1:0]        m0_data_read_n,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_data_in,
  input  logic [1:0]        m1_data_write_n,
  input  logic [1:0]        m1_data_read_n,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_data_in,
  output logic [1:0]        bus_data_write_n,
  output logic [1:0]        bus_data_read_n,
  output logic              is_read
);

  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_data;
  logic [1:0]        sel_write_n;
  logic [1:0]        sel_read_n;

  assign sel_addr    = sel ? m1_addr         : m0_addr;
  assign sel_data    = sel ? m1_data_in      : m0_data_in;
  assign sel_write_n = sel ? m1_data_write_n : m0_data_write_n;
  // A write takes precedence; a simultaneous read request is dropped.
  assign sel_read_n  = (sel_write_n != REQ_NONE) ? REQ_NONE
                     : (sel ? m1_data_read_n : m0_data_read_n);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_addr         <= '0;
      bus_data_in      <= '0;
      bus_data_write_n <= REQ_NONE;
      bus_data_read_n  <= REQ_NONE;
    end else if (load) begin
      bus_addr         <= sel_addr;
      bus_data_in      <= sel_data;
      bus_data_write_n <= sel_write_n;
      bus_data_read_n  <= sel_read_n;
    end else if (clear) begin
      bus_addr         <= '0;
      bus_data_in      <= '0;
      bus_data_write_n <= REQ_NONE;
      bus_data_read_n  <= REQ_NONE;
    end
  end

  assign is_read = (bus_data_read_n != REQ_NONE);

endmodule

// File: rtl/peri_bus_arbiter.sv
// Two-master round-robin arbiter for the peripheral register bus.
// Define PERI_ARB_TIMEOUT_EN to abort transactions the peripheral never completes.
module peri_bus_arbiter
  import peri_arb_pkg::*;
#(
  parameter int ADDR_W         = 11,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_data_in,
  input  logic [1:0]        m0_data_write_n,
  input  logic [1:0]        m0_data_read_n,
  output logic [31:0]       m0_data_out,
  output logic              m0_data_ready,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_data_in,
  input  logic [1:0]        m1_data_write_n,
  input  logic [1:0]        m1_data_read_n,
  output logic [31:0]       m1_data_out,
  output logic              m1_data_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_data_in,
  output logic [1:0]        bus_data_write_n,
  output logic [1:0]        bus_data_read_n,
  input  logic [31:0]       bus_data_out,
  input  logic              bus_data_ready,
  output logic              bus_data_read_complete,
  output logic [1:0]        grant,
  output logic              timeout
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  arb_state_e  state_q, state_d;
  logic        req0, req1, owner_req, winner;
  logic        last_grant_q;
  logic        load, done, abort, drop, is_read, cnt_hit;
  logic [31:0] ret_data;

  assign req0      = req_active(m0_data_write_n, m0_data_read_n);
  assign req1      = req_active(m1_data_write_n, m1_data_read_n);
  // On a tie the master that did not win last time goes next.
  assign winner    = (req0 && req1) ? ~last_grant_q : req1;
  assign owner_req = last_grant_q ? req1 : req0;
  assign ret_data  = abort ? ABORT_DATA : bus_data_out;

`ifdef PERI_ARB_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q;
  logic       timeout_q;

  assign cnt_hit = (cnt_q == CNT_LAST);
  assign timeout = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= abort;
      if (load)                 cnt_q <= '0;
      else if (state_q == ISSUE) cnt_q <= cnt_q + 8'd1;
    end
  end
`else
  assign cnt_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          load    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus_data_ready) begin
          done    = 1'b1;
          state_d = RELEASE;
        end else if (cnt_hit) begin
          abort   = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!owner_req) begin
          drop    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant                  <= 2'b00;
      last_grant_q           <= 1'b1;
      m0_data_ready          <= 1'b0;
      m1_data_ready          <= 1'b0;
      m0_data_out            <= '0;
      m1_data_out            <= '0;
      bus_data_read_complete <= 1'b0;
    end else begin
      m0_data_ready          <= 1'b0;
      m1_data_ready          <= 1'b0;
      bus_data_read_complete <= 1'b0;
      if (load) begin
        grant        <= winner ? 2'b10 : 2'b01;
        last_grant_q <= winner;
      end
      if (drop) grant <= 2'b00;
      if (done || abort) begin
        if (last_grant_q) m1_data_ready <= 1'b1;
        else              m0_data_ready <= 1'b1;
        if (is_read) begin
          if (last_grant_q) m1_data_out <= ret_data;
          else              m0_data_out <= ret_data;
        end
        bus_data_read_complete <= is_read && done;
      end
    end
  end

  peri_arb_req_latch #(.ADDR_W(ADDR_W)) u_req_latch (
    .clk              (clk),
    .rst_n            (rst_n),
    .load             (load),
    .clear            (done || abort),
    .sel              (winner),
    .m0_addr          (m0_addr),
    .m0_data_in       (m0_data_in),
    .m0_data_write_n  (m0_data_write_n),
    .m0_data_read_n   (m0_data_read_n),
    .m1_addr          (m1_addr),
    .m1_data_in       (m1_data_in),
    .m1_data_write_n  (m1_data_write_n),
    .m1_data_read_n   (m1_data_read_n),
    .bus_addr         (bus_addr),
    .bus_data_in      (bus_data_in),
    .bus_data_write_n (bus_data_write_n),
    .bus_data_read_n  (bus_data_read_n),
    .is_read          (is_read)
  );

endmodule

// File: tb/tb_peri_bus_arbiter.sv
// Scoreboard bench for peri_bus_arbiter; the timeout scenario runs when PERI_ARB_TIMEOUT_EN is defined.
module tb_peri_bus_arbiter;
  import peri_arb_pkg::*;

  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] m_addr [2];
  logic [31:0]       m_data [2];
  logic [1:0]        m_wn   [2];
  logic [1:0]        m_rn   [2];
  logic [31:0]       m0_dout, m1_dout;
  logic              m0_rdy, m1_rdy;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_data_in, bus_data_out;
  logic [1:0]        bus_wn, bus_rn, grant;
  logic              bus_data_ready, read_complete, timeout;

  peri_bus_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(m_addr[0]), .m0_data_in(m_data[0]), .m0_data_write_n(m_wn[0]), .m0_data_read_n(m_rn[0]),
    .m0_data_out(m0_dout), .m0_data_ready(m0_rdy),
    .m1_addr(m_addr[1]), .m1_data_in(m_data[1]), .m1_data_write_n(m_wn[1]), .m1_data_read_n(m_rn[1]),
    .m1_data_out(m1_dout), .m1_data_ready(m1_rdy),
    .bus_addr(bus_addr), .bus_data_in(bus_data_in), .bus_data_write_n(bus_wn), .bus_data_read_n(bus_rn),
    .bus_data_out(bus_data_out), .bus_data_ready(bus_data_ready),
    .bus_data_read_complete(read_complete), .grant(grant), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          master;
    logic [31:0] dout;
    bit          rc;
    bit          to;
  } exp_t;

  exp_t              sb[$];
  int                checks = 0;
  int                failures = 0;
  logic [31:0]       model_dout [2];
  logic [31:0]       periph_rdata [2];
  logic [ADDR_W-1:0] lat_addr [2];
  logic [31:0]       lat_data [2];
  logic [1:0]        lat_wn [2];
  logic [1:0]        lat_rn [2];

  localparam logic [ADDR_W+35:0] BUS_IDLE = {{ADDR_W{1'b0}}, 32'h0, 2'b11, 2'b11};

  function automatic logic [1:0] onehot(input bit m);
    return m ? 2'b10 : 2'b01;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue_req(input bit m, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                           input logic [1:0] wn, input logic [1:0] rn, input logic [31:0] rdata,
                           input bit aborts);
    exp_t e;
    m_addr[m] = a; m_data[m] = d; m_wn[m] = wn; m_rn[m] = rn;
    lat_addr[m] = a; lat_data[m] = d; lat_wn[m] = wn;
    lat_rn[m] = (wn != 2'b11) ? 2'b11 : rn;
    periph_rdata[m] = rdata;
    e.master = m;
    e.to     = aborts;
    e.rc     = (lat_rn[m] != 2'b11) && !aborts;
    if (lat_rn[m] != 2'b11) e.dout = aborts ? 32'hFFFF_FFFF : rdata;
    else                    e.dout = model_dout[m];
    model_dout[m] = e.dout;
    sb.push_back(e);
  endtask

  task automatic drop_req(input bit m);
    m_wn[m] = 2'b11;
    m_rn[m] = 2'b11;
  endtask

  task automatic wait_grant(input bit m, input int exp_lat, input string tag);
    int n = 0;
    while (bus_wn === 2'b11 && bus_rn === 2'b11 && n < 20) begin
      tick;
      n++;
    end
    checks++; if (n !== exp_lat) begin failures++; $display("FAIL %s latency: got %0d want %0d", tag, n, exp_lat); end
    checks++; if (grant !== onehot(m)) begin failures++; $display("FAIL %s grant: got %b want %b", tag, grant, onehot(m)); end
    checks++;
    if ({bus_addr, bus_data_in, bus_wn, bus_rn} !== {lat_addr[m], lat_data[m], lat_wn[m], lat_rn[m]}) begin
      failures++;
      $display("FAIL %s bus: got %h/%h/%b/%b want %h/%h/%b/%b", tag, bus_addr, bus_data_in, bus_wn, bus_rn,
               lat_addr[m], lat_data[m], lat_wn[m], lat_rn[m]);
    end
  endtask

  task automatic pop_compare(input bit m, input string tag);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++; $display("FAIL %s scoreboard: got ready pulse want none pending", tag);
      return;
    end
    e = sb.pop_front();
    checks++; if (e.master !== m) begin failures++; $display("FAIL %s owner: got m%0d want m%0d", tag, m, e.master); end
    checks++;
    if ((m ? m1_dout : m0_dout) !== e.dout) begin
      failures++; $display("FAIL %s data_out: got %h want %h", tag, m ? m1_dout : m0_dout, e.dout);
    end
    checks++; if (read_complete !== e.rc) begin failures++; $display("FAIL %s read_complete: got %b want %b", tag, read_complete, e.rc); end
    checks++; if (timeout !== e.to) begin failures++; $display("FAIL %s timeout: got %b want %b", tag, timeout, e.to); end
  endtask

  task automatic finish_txn(input bit m, input int delay, input string tag);
    for (int i = 0; i < delay; i++) begin
      tick;
      checks++;
      if ({bus_addr, bus_data_in, bus_wn, bus_rn, m1_rdy, m0_rdy, timeout} !==
          {lat_addr[m], lat_data[m], lat_wn[m], lat_rn[m], 3'b000}) begin
        failures++;
        $display("FAIL %s hold: got %h/%h/%b/%b rdy=%b%b to=%b", tag, bus_addr, bus_data_in, bus_wn, bus_rn,
                 m1_rdy, m0_rdy, timeout);
      end
    end
    bus_data_out   = periph_rdata[m];
    bus_data_ready = 1'b1;
    tick;
    bus_data_ready = 1'b0;
    bus_data_out   = 32'hDEAD_BEEF;
    checks++; if ({m1_rdy, m0_rdy} !== onehot(m)) begin failures++; $display("FAIL %s ready: got %b%b want %b", tag, m1_rdy, m0_rdy, onehot(m)); end
    checks++; if ({bus_addr, bus_data_in, bus_wn, bus_rn} !== BUS_IDLE) begin failures++; $display("FAIL %s bus idle: got %h/%h/%b/%b", tag, bus_addr, bus_data_in, bus_wn, bus_rn); end
    checks++; if (grant !== onehot(m)) begin failures++; $display("FAIL %s release grant: got %b want %b", tag, grant, onehot(m)); end
    pop_compare(m, tag);
  endtask

  task automatic release_bus(input bit m, input int hold, input string tag);
    for (int i = 0; i < hold; i++) begin
      tick;
      checks++;
      if ({bus_addr, bus_data_in, bus_wn, bus_rn, grant, m1_rdy, m0_rdy, read_complete, timeout} !==
          {BUS_IDLE, onehot(m), 4'b0000}) begin
        failures++;
        $display("FAIL %s release hold: got bus %b/%b grant %b rdy %b%b rc %b to %b", tag, bus_wn, bus_rn,
                 grant, m1_rdy, m0_rdy, read_complete, timeout);
      end
    end
    drop_req(m);
    tick;
    checks++;
    if ({bus_addr, bus_data_in, bus_wn, bus_rn, grant, m1_rdy, m0_rdy, read_complete} !== {BUS_IDLE, 5'b00000}) begin
      failures++;
      $display("FAIL %s handback: got bus %b/%b grant %b rdy %b%b rc %b", tag, bus_wn, bus_rn, grant,
               m1_rdy, m0_rdy, read_complete);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({bus_addr, bus_data_in, bus_wn, bus_rn, grant, m1_rdy, m0_rdy, read_complete, timeout, m0_dout, m1_dout} !==
        {BUS_IDLE, 6'b000000, 64'h0}) begin
      failures++;
      $display("FAIL %s: got bus %h/%h/%b/%b grant %b rdy %b%b rc %b to %b dout %h/%h", tag, bus_addr,
               bus_data_in, bus_wn, bus_rn, grant, m1_rdy, m0_rdy, read_complete, timeout, m0_dout, m1_dout);
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      drop_req(i[0]); m_addr[i] = '0; m_data[i] = '0; model_dout[i] = '0;
    end
    bus_data_ready = 1'b0;
    bus_data_out   = 32'h0;
    repeat (3) tick;
    check_reset_outputs("reset");
    rst_n = 1'b1;
  endtask

  task automatic test_write_single;
    issue_req(1'b0, 11'h040, 32'h0000_00A5, 2'b10, 2'b11, 32'h0, 1'b0);
    wait_grant(1'b0, 1, "write_m0");
    finish_txn(1'b0, 0, "write_m0");
    release_bus(1'b0, 0, "write_m0");
  endtask

  task automatic test_read_m1;
    issue_req(1'b1, 11'h5C0, 32'h0, 2'b11, 2'b10, 32'h1234_5678, 1'b0);
    wait_grant(1'b1, 1, "read_m1");
    finish_txn(1'b1, 2, "read_m1");
    release_bus(1'b1, 1, "read_m1");
  endtask

  task automatic test_round_robin;
    issue_req(1'b0, 11'h001, 32'h0000_0011, 2'b00, 2'b11, 32'h0, 1'b0);
    issue_req(1'b1, 11'h102, 32'h0, 2'b11, 2'b01, 32'h0000_BEEF, 1'b0);
    wait_grant(1'b0, 1, "rr1_m0");
    finish_txn(1'b0, 0, "rr1_m0");
    release_bus(1'b0, 3, "rr1_m0");
    issue_req(1'b0, 11'h203, 32'h0000_3333, 2'b01, 2'b10, 32'h7777_7777, 1'b0);
    wait_grant(1'b1, 1, "rr2_m1");
    finish_txn(1'b1, 1, "rr2_m1");
    release_bus(1'b1, 0, "rr2_m1");
    issue_req(1'b1, 11'h304, 32'h0, 2'b11, 2'b00, 32'h0000_00C3, 1'b0);
    wait_grant(1'b0, 1, "rr3_m0");
    finish_txn(1'b0, 2, "rr3_m0");
    release_bus(1'b0, 0, "rr3_m0");
    wait_grant(1'b1, 1, "rr4_m1");
    finish_txn(1'b1, 0, "rr4_m1");
    release_bus(1'b1, 0, "rr4_m1");
  endtask

  task automatic test_mid_change;
    issue_req(1'b0, 11'h123, 32'hCAFE_0001, 2'b11, 2'b10, 32'h0BAD_F00D, 1'b0);
    wait_grant(1'b0, 1, "mid_change");
    m_addr[0] = 11'h7FF;
    m_data[0] = 32'h5555_AAAA;
    finish_txn(1'b0, 2, "mid_change");
    release_bus(1'b0, 0, "mid_change");
  endtask

  task automatic test_async_reset;
    issue_req(1'b0, 11'h010, 32'h0, 2'b11, 2'b10, 32'hA0A0_0001, 1'b0);
    issue_req(1'b1, 11'h020, 32'h0, 2'b11, 2'b10, 32'hB0B0_0002, 1'b0);
    wait_grant(1'b1, 1, "pre_reset_tie");
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    sb.delete();
    model_dout[0] = '0;
    model_dout[1] = '0;
    tick;
    check_reset_outputs("reset_held");
    #2;
    rst_n = 1'b1;
    issue_req(1'b0, 11'h010, 32'h0, 2'b11, 2'b10, 32'hA0A0_0001, 1'b0);
    issue_req(1'b1, 11'h020, 32'h0, 2'b11, 2'b10, 32'hB0B0_0002, 1'b0);
    wait_grant(1'b0, 1, "post_reset_tie");
    finish_txn(1'b0, 0, "post_reset_m0");
    release_bus(1'b0, 0, "post_reset_m0");
    wait_grant(1'b1, 1, "post_reset_m1");
    finish_txn(1'b1, 1, "post_reset_m1");
    release_bus(1'b1, 0, "post_reset_m1");
  endtask

`ifdef PERI_ARB_TIMEOUT_EN
  task automatic test_timeout;
    issue_req(1'b0, 11'h030, 32'h0, 2'b11, 2'b10, 32'h0, 1'b1);
    wait_grant(1'b0, 1, "timeout");
    repeat (3) begin
      tick;
      checks++;
      if ({m1_rdy, m0_rdy, timeout, bus_rn} !== {3'b000, 2'b10}) begin
        failures++; $display("FAIL timeout wait: got rdy %b%b to %b rn %b", m1_rdy, m0_rdy, timeout, bus_rn);
      end
    end
    tick;
    checks++; if (m0_rdy !== 1'b1) begin failures++; $display("FAIL timeout ready: got %b want 1", m0_rdy); end
    checks++; if ({bus_addr, bus_data_in, bus_wn, bus_rn} !== BUS_IDLE) begin failures++; $display("FAIL timeout bus idle: got %b/%b", bus_wn, bus_rn); end
    pop_compare(1'b0, "timeout");
    release_bus(1'b0, 0, "timeout");
  endtask
`else
  task automatic test_no_timeout;
    issue_req(1'b0, 11'h030, 32'h0, 2'b11, 2'b10, 32'h600D_0001, 1'b0);
    wait_grant(1'b0, 1, "long_wait");
    finish_txn(1'b0, 10, "long_wait");
    release_bus(1'b0, 0, "long_wait");
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_write_single;
    test_read_m1;
    test_round_robin;
    test_mid_change;
    test_async_reset;
`ifdef PERI_ARB_TIMEOUT_EN
    test_timeout;
`else
    test_no_timeout;
`endif
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL scoreboard drain: got %0d pending want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
